// File: rtl/vme_a24_slave_pkg.sv
// vme_a24_slave_pkg: shared definitions for the VME A24/D32 slave.
//   - A24 address-modifier codes accepted by the slave (user and supervisor data)
//   - FSM state encoding
//   - geographic-address helpers (parity check, slot extraction)
package vme_a24_slave_pkg;

  localparam logic [5:0] c_AM_A24_USER = 6'h39;
  localparam logic [5:0] c_AM_A24_SUP  = 6'h3D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_WAIT_DS,
    ST_ACCESS,
    ST_RDSETUP,
    ST_DTACK,
    ST_ERROR,
    ST_WAIT_END
  } t_vme_slave_state;

  // GA pins carry {parity, ~slot}; the backplane wiring gives odd parity.
  function automatic logic f_ga_valid(input logic [5:0] ga);
    return ^ga;
  endfunction

  function automatic logic [4:0] f_ga_slot(input logic [5:0] ga);
    return ~ga[4:0];
  endfunction

endpackage

// File: rtl/vme_input_sync.sv
// vme_input_sync: W-bit two-flop synchroniser for asynchronous VME strobes.
//   clk_i, rst_i : clock, synchronous active-high reset
//   i_d          : asynchronous inputs
//   o_q          : synchronised outputs (reset to RST_VAL, i.e. strobes inactive)
module vme_input_sync #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/vme_a24_slave.sv
// vme_a24_slave: VME64x A24 single-cycle D32 slave bridged to a local
// request/acknowledge register bus.
//   clk_i/rst_i        : clock, synchronous active-high reset
//   vme_*_i            : VME backplane inputs (strobes asynchronous, GA static)
//   vme_data_o         : read data toward the bus
//   vme_dtack_*/berr_o : cycle termination drivers
//   vme_data_dir/oe_n  : data transceiver control; address transceiver tied on
//   bus_*              : local bus, one req/ack handshake per VME cycle
module vme_a24_slave
  import vme_a24_slave_pkg::*;
#(
  parameter int g_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        vme_as_n_i,
  input  logic [1:0]  vme_ds_n_i,
  input  logic        vme_write_n_i,
  input  logic [5:0]  vme_am_i,
  input  logic [5:0]  vme_ga_i,
  input  logic        vme_lword_n_i,
  input  logic [31:1] vme_addr_i,
  input  logic [31:0] vme_data_i,
  output logic [31:0] vme_data_o,
  output logic        vme_dtack_n_o,
  output logic        vme_dtack_oe_o,
  output logic        vme_berr_o,
  output logic        vme_data_dir_o,
  output logic        vme_data_oe_n_o,
  output logic        vme_addr_dir_o,
  output logic        vme_addr_oe_n_o,
  output logic [16:0] bus_addr_o,
  output logic [31:0] bus_dat_o,
  input  logic [31:0] bus_dat_i,
  output logic        bus_we_o,
  output logic        bus_req_o,
  input  logic        bus_ack_i
);

  localparam logic [9:0] c_TO_LAST = 10'(g_TIMEOUT - 1);

  logic [3:0]       w_sync;
  logic             w_as_n;
  logic [1:0]       w_ds_n;
  logic             w_write_n;
  logic             w_match;
  logic             w_d32;
  logic             w_unused;

  t_vme_slave_state r_state;
  t_vme_slave_state w_next;

  logic [23:1]      r_addr;
  logic [5:0]       r_am;
  logic             r_lword_n;
  logic             r_we;
  logic [9:0]       r_cnt;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;

  vme_input_sync #(.W(4), .RST_VAL(4'hF)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .i_d   ({vme_as_n_i, vme_ds_n_i, vme_write_n_i}),
    .o_q   (w_sync)
  );

  assign {w_as_n, w_ds_n, w_write_n} = w_sync;

  // Only A23..A1 are decoded; upper address lines are don't-care in A24.
  assign w_unused = &{1'b0, vme_addr_i[31:24]};

  assign w_match = f_ga_valid(vme_ga_i) && (f_ga_slot(vme_ga_i) != 5'd0) &&
                   ((r_am == c_AM_A24_USER) || (r_am == c_AM_A24_SUP)) &&
                   (r_addr[23:19] == f_ga_slot(vme_ga_i));

  assign w_d32 = (w_ds_n == 2'b00) && !r_lword_n && !r_addr[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    vme_dtack_n_o   = 1'b1;
    vme_dtack_oe_o  = 1'b0;
    vme_berr_o      = 1'b0;
    vme_data_dir_o  = 1'b0;
    vme_data_oe_n_o = 1'b1;
    bus_req_o       = 1'b0;
    bus_we_o        = 1'b0;
    case (r_state)
      ST_IDLE:     if (!w_as_n) w_next = ST_DECODE;
      ST_DECODE:   w_next = w_match ? ST_WAIT_DS : ST_WAIT_END;
      ST_WAIT_DS: begin
        vme_data_oe_n_o = w_write_n;
        // Any strobe low starts the check; a single-strobe (D16/D08)
        // transfer is not D32 and terminates with BERR.
        if (w_ds_n != 2'b11) w_next = w_d32 ? ST_ACCESS : ST_ERROR;
      end
      ST_ACCESS: begin
        bus_req_o       = 1'b1;
        bus_we_o        = r_we;
        vme_data_oe_n_o = !r_we;
        // ack is tested before the timeout so a last-cycle ack still wins
        if (bus_ack_i)                w_next = r_we ? ST_DTACK : ST_RDSETUP;
        else if (r_cnt == c_TO_LAST)  w_next = ST_ERROR;
      end
      ST_RDSETUP: begin
        vme_data_dir_o  = 1'b1;
        vme_data_oe_n_o = 1'b0;
        w_next          = ST_DTACK;
      end
      ST_DTACK: begin
        vme_dtack_oe_o  = 1'b1;
        vme_dtack_n_o   = 1'b0;
        vme_data_dir_o  = !r_we;
        vme_data_oe_n_o = 1'b0;
        if (w_ds_n == 2'b11) w_next = ST_WAIT_END;
      end
      ST_ERROR: begin
        vme_berr_o = 1'b1;
        if (w_ds_n == 2'b11) w_next = ST_WAIT_END;
      end
      ST_WAIT_END: if (w_as_n) w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
    // Master abort: AS released early drops everything.
    if ((r_state != ST_IDLE) && w_as_n) w_next = ST_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr    <= '0;
      r_am      <= '0;
      r_lword_n <= 1'b1;
      r_we      <= 1'b0;
      r_cnt     <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
    end else begin
      if ((r_state == ST_IDLE) && !w_as_n) begin
        r_addr    <= vme_addr_i[23:1];
        r_am      <= vme_am_i;
        r_lword_n <= vme_lword_n_i;
      end
      if ((r_state == ST_WAIT_DS) && (w_next == ST_ACCESS)) begin
        r_we <= !w_write_n;
        if (!w_write_n) r_wdata <= vme_data_i;
      end
      if ((r_state == ST_ACCESS) && (w_next == ST_RDSETUP)) r_rdata <= bus_dat_i;
      r_cnt <= (r_state == ST_ACCESS) ? r_cnt + 10'd1 : '0;
    end
  end

  assign bus_addr_o      = r_addr[18:2];
  assign bus_dat_o       = r_wdata;
  assign vme_data_o      = r_rdata;
  assign vme_addr_dir_o  = 1'b0;
  assign vme_addr_oe_n_o = 1'b0;

endmodule

// File: tb/tb_vme_a24_slave.sv
// Directed bench for vme_a24_slave (g_TIMEOUT = 8). Slot 5 is wired as
// GA = 6'b011010: ~GA[4:0] = 5 and the six bits XOR to 1 (valid parity).
module tb_vme_a24_slave;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        vme_as_n_i = 1'b1;
  logic [1:0]  vme_ds_n_i = 2'b11;
  logic        vme_write_n_i = 1'b1;
  logic [5:0]  vme_am_i = 6'h00;
  logic [5:0]  vme_ga_i = 6'b011010;
  logic        vme_lword_n_i = 1'b1;
  logic [31:1] vme_addr_i = '0;
  logic [31:0] vme_data_i = '0;
  logic [31:0] vme_data_o;
  logic        vme_dtack_n_o, vme_dtack_oe_o, vme_berr_o;
  logic        vme_data_dir_o, vme_data_oe_n_o, vme_addr_dir_o, vme_addr_oe_n_o;
  logic [16:0] bus_addr_o;
  logic [31:0] bus_dat_o;
  logic [31:0] bus_dat_i = '0;
  logic        bus_we_o, bus_req_o;
  logic        bus_ack_i = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  vme_a24_slave #(.g_TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .vme_as_n_i(vme_as_n_i), .vme_ds_n_i(vme_ds_n_i), .vme_write_n_i(vme_write_n_i),
    .vme_am_i(vme_am_i), .vme_ga_i(vme_ga_i), .vme_lword_n_i(vme_lword_n_i),
    .vme_addr_i(vme_addr_i), .vme_data_i(vme_data_i), .vme_data_o(vme_data_o),
    .vme_dtack_n_o(vme_dtack_n_o), .vme_dtack_oe_o(vme_dtack_oe_o), .vme_berr_o(vme_berr_o),
    .vme_data_dir_o(vme_data_dir_o), .vme_data_oe_n_o(vme_data_oe_n_o),
    .vme_addr_dir_o(vme_addr_dir_o), .vme_addr_oe_n_o(vme_addr_oe_n_o),
    .bus_addr_o(bus_addr_o), .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i),
    .bus_we_o(bus_we_o), .bus_req_o(bus_req_o), .bus_ack_i(bus_ack_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return bus_req_o;
      1:       return vme_dtack_n_o;
      default: return vme_berr_o;
    endcase
  endfunction

  // Edges until the selected output reaches lvl (bounded).
  task automatic wait_sig(input int sel, input logic lvl, output int n);
    n = 0;
    while (pick(sel) !== lvl && n < 40) begin
      tick(1);
      n++;
    end
  endtask

  task automatic vme_begin(input logic [23:0] a, input logic [5:0] am, input logic wr,
                           input logic [31:0] d, input logic [1:0] ds);
    vme_addr_i    = {8'd0, a[23:1]};
    vme_am_i      = am;
    vme_write_n_i = ~wr;
    vme_data_i    = d;
    vme_lword_n_i = 1'b0;
    vme_as_n_i    = 1'b0;
    tick(4);
    vme_ds_n_i    = ds;
  endtask

  task automatic vme_end();
    vme_ds_n_i = 2'b11;
    tick(4);
    vme_as_n_i = 1'b1;
    tick(4);
  endtask

  task automatic ack_pulse();
    bus_ack_i = 1'b1;
    tick(1);
    bus_ack_i = 1'b0;
  endtask

  logic [5:0]  nm_ga [4] = '{6'b011010, 6'b011010, 6'b111010, 6'b011111};
  logic [23:0] nm_a  [4] = '{24'h30_0000, 24'h28_0010, 24'h28_0010, 24'h00_0010};
  logic [5:0]  nm_am [4] = '{6'h39, 6'h09, 6'h39, 6'h39};

  initial begin
    int  n;
    logic s_req, s_dt, s_be;

    tick(3);
    chk("rst_dtack_n", vme_dtack_n_o, 1);
    chk("rst_dtack_oe", vme_dtack_oe_o, 0);
    chk("rst_berr", vme_berr_o, 0);
    chk("rst_dir", vme_data_dir_o, 0);
    chk("rst_oe_n", vme_data_oe_n_o, 1);
    chk("rst_rdata", vme_data_o, 0);
    chk("rst_adir", vme_addr_dir_o, 0);
    chk("rst_aoe_n", vme_addr_oe_n_o, 0);
    chk("rst_req", bus_req_o, 0);
    chk("rst_we", bus_we_o, 0);
    chk("rst_addr", bus_addr_o, 0);
    chk("rst_dat", bus_dat_o, 0);
    rst_i = 1'b0;
    tick(2);

    // Write, slot 5, ack four cycles into the request
    vme_begin(24'h28_0010, 6'h39, 1'b1, 32'hDEADBEEF, 2'b00);
    wait_sig(0, 1'b1, n);
    chk("wr_req_lat", n, 3);
    chk("wr_addr", bus_addr_o, 32'h4);
    chk("wr_dat", bus_dat_o, 32'hDEADBEEF);
    chk("wr_we", bus_we_o, 1);
    chk("wr_oe_n", vme_data_oe_n_o, 0);
    chk("wr_dir", vme_data_dir_o, 0);
    tick(3);
    chk("wr_req_hold", bus_req_o, 1);
    ack_pulse();
    chk("wr_dtack_n", vme_dtack_n_o, 0);
    chk("wr_dtack_oe", vme_dtack_oe_o, 1);
    chk("wr_berr", vme_berr_o, 0);
    chk("wr_req_off", bus_req_o, 0);
    vme_ds_n_i = 2'b11;
    wait_sig(1, 1'b1, n);
    chk("wr_dtack_rel", n, 3);
    chk("wr_end_oe_n", vme_data_oe_n_o, 1);
    vme_as_n_i = 1'b1;
    tick(4);

    // Read, supervisor AM
    bus_dat_i = 32'h12345678;
    vme_begin(24'h28_0010, 6'h3D, 1'b0, 32'h0, 2'b00);
    wait_sig(0, 1'b1, n);
    chk("rd_req_lat", n, 3);
    chk("rd_we", bus_we_o, 0);
    chk("rd_oe_n_acc", vme_data_oe_n_o, 1);
    tick(2);
    ack_pulse();
    chk("rd_data", vme_data_o, 32'h12345678);
    chk("rd_dir", vme_data_dir_o, 1);
    chk("rd_oe_n", vme_data_oe_n_o, 0);
    chk("rd_dtack_early", vme_dtack_n_o, 1);
    tick(1);
    chk("rd_dtack_n", vme_dtack_n_o, 0);
    chk("rd_dir_dt", vme_data_dir_o, 1);
    vme_end();

    // ack in the final timeout cycle still completes the write
    vme_begin(24'h28_0014, 6'h39, 1'b1, 32'h5A5A0001, 2'b00);
    wait_sig(0, 1'b1, n);
    tick(7);
    chk("edge_req", bus_req_o, 1);
    ack_pulse();
    chk("edge_dtack_n", vme_dtack_n_o, 0);
    chk("edge_berr", vme_berr_o, 0);
    chk("edge_addr", bus_addr_o, 32'h5);
    vme_end();

    // Timeout: read with no ack
    bus_dat_i = 32'hFFFF0000;
    vme_begin(24'h28_0010, 6'h39, 1'b0, 32'h0, 2'b00);
    wait_sig(0, 1'b1, n);
    n = 0;
    while (bus_req_o && n < 40) begin
      n++;
      tick(1);
    end
    chk("to_req_cycles", n, 8);
    chk("to_berr", vme_berr_o, 1);
    ack_pulse();
    chk("to_berr_hold", vme_berr_o, 1);
    chk("to_dtack_n", vme_dtack_n_o, 1);
    chk("to_rdata_kept", vme_data_o, 32'h12345678);
    vme_end();
    chk("to_berr_rel", vme_berr_o, 0);

    // D16 (single data strobe): BERR, no local request
    vme_begin(24'h28_0010, 6'h39, 1'b0, 32'h0, 2'b01);
    wait_sig(2, 1'b1, n);
    chk("d16_berr_lat", n, 3);
    chk("d16_req", bus_req_o, 0);
    vme_ds_n_i = 2'b11;
    wait_sig(2, 1'b0, n);
    chk("d16_berr_rel", n, 3);
    vme_as_n_i = 1'b1;
    tick(4);

    // Non-matching cycles: wrong slot, wrong AM, bad GA parity, slot 0
    for (int i = 0; i < 4; i++) begin
      vme_ga_i = nm_ga[i];
      vme_begin(nm_a[i], nm_am[i], 1'b1, 32'h1, 2'b00);
      s_req = 1'b0; s_dt = 1'b0; s_be = 1'b0;
      repeat (12) begin
        tick(1);
        s_req |= bus_req_o;
        s_dt  |= ~vme_dtack_n_o | vme_dtack_oe_o;
        s_be  |= vme_berr_o;
      end
      chk($sformatf("nm%0d_req", i), s_req, 0);
      chk($sformatf("nm%0d_dtack", i), s_dt, 0);
      chk($sformatf("nm%0d_berr", i), s_be, 0);
      vme_end();
    end
    vme_ga_i = 6'b011010;

    // Abort: AS released while the request is pending
    bus_dat_i = 32'hAAAA5555;
    vme_begin(24'h28_0010, 6'h39, 1'b0, 32'h0, 2'b00);
    wait_sig(0, 1'b1, n);
    chk("ab_req_lat", n, 3);
    vme_as_n_i = 1'b1;
    vme_ds_n_i = 2'b11;
    tick(2);
    chk("ab_req_hold", bus_req_o, 1);
    tick(1);
    chk("ab_req_drop", bus_req_o, 0);
    ack_pulse();
    chk("ab_dtack_n", vme_dtack_n_o, 1);
    chk("ab_dtack_oe", vme_dtack_oe_o, 0);
    chk("ab_berr", vme_berr_o, 0);
    chk("ab_oe_n", vme_data_oe_n_o, 1);
    chk("ab_rdata", vme_data_o, 32'h12345678);
    tick(2);

    // Reset during DTACK, then a clean write
    vme_begin(24'h28_0020, 6'h39, 1'b1, 32'hCAFEF00D, 2'b00);
    wait_sig(0, 1'b1, n);
    chk("rs_req_lat", n, 3);
    tick(1);
    ack_pulse();
    chk("rs_dtack_pre", vme_dtack_n_o, 0);
    rst_i      = 1'b1;
    vme_as_n_i = 1'b1;
    vme_ds_n_i = 2'b11;
    tick(1);
    chk("rs_dtack_n", vme_dtack_n_o, 1);
    chk("rs_dtack_oe", vme_dtack_oe_o, 0);
    chk("rs_oe_n", vme_data_oe_n_o, 1);
    chk("rs_addr", bus_addr_o, 0);
    chk("rs_dat", bus_dat_o, 0);
    chk("rs_rdata", vme_data_o, 0);
    chk("rs_req", bus_req_o, 0);
    rst_i = 1'b0;
    tick(2);
    vme_begin(24'h28_0010, 6'h39, 1'b1, 32'h0BADCAFE, 2'b00);
    wait_sig(0, 1'b1, n);
    chk("post_req_lat", n, 3);
    chk("post_dat", bus_dat_o, 32'h0BADCAFE);
    chk("post_addr", bus_addr_o, 32'h4);
    ack_pulse();
    chk("post_dtack_n", vme_dtack_n_o, 0);
    vme_end();
    chk("post_dtack_rel", vme_dtack_n_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
